// File: rtl/fp_mult_pkg.sv
// Shared FP multiplier definitions: default field widths, the special-operand
// code carried through the pipeline, and the canonical quiet-NaN mantissa.
package fp_mult_pkg;

  localparam int unsigned DEF_EXP_W = 5;
  localparam int unsigned DEF_MAN_W = 10;
  localparam int unsigned DEF_BIAS  = (1 << (DEF_EXP_W - 1)) - 1;

  // Special-operand class resolved before normalisation
  typedef enum logic [1:0] {
    SPC_NONE = 2'd0,
    SPC_ZERO = 2'd1,
    SPC_INF  = 2'd2,
    SPC_NAN  = 2'd3
  } spc_e;

  // Canonical qNaN mantissa: only the top stored bit set
  localparam logic [DEF_MAN_W-1:0] QNAN_MAN = {1'b1, {(DEF_MAN_W - 1){1'b0}}};

endpackage

// File: rtl/fp_mult_norm_round_if.sv
// Valid/ready bus between the significand multiplier, the normalise/round
// stage and its consumer.
//   in_*  : raw product, exponent sum, sign and special flags (+ handshake)
//   out_* : packed {sign, exp, mantissa} result and exception flags
// master = producer/consumer side, slave = fp_mult_norm_round.
interface fp_mult_norm_round_if
  import fp_mult_pkg::*;
#(
  parameter int unsigned EXP_W = DEF_EXP_W,
  parameter int unsigned MAN_W = DEF_MAN_W
);

  logic                     in_valid;
  logic                     in_ready;
  logic [2*MAN_W+1:0]       in_prod;
  logic [EXP_W:0]           in_exp_sum;
  logic                     in_sign;
  logic                     in_zero;
  logic                     in_inf;
  logic                     in_nan;
  logic                     out_valid;
  logic                     out_ready;
  logic [EXP_W+MAN_W:0]     out_result;
  logic                     out_ovf;
  logic                     out_unf;
  logic                     out_inexact;

  modport master (
    output in_valid, in_prod, in_exp_sum, in_sign, in_zero, in_inf, in_nan, out_ready,
    input  in_ready, out_valid, out_result, out_ovf, out_unf, out_inexact
  );

  modport slave (
    input  in_valid, in_prod, in_exp_sum, in_sign, in_zero, in_inf, in_nan, out_ready,
    output in_ready, out_valid, out_result, out_ovf, out_unf, out_inexact
  );

endinterface

// File: rtl/fp_rne_round.sv
// Round-to-nearest-even of a truncated mantissa.
//   man_i, guard_i, sticky_i : truncated mantissa and the discarded bits
//   man_c, carry_c           : rounded mantissa and carry out of its MSB
// Purely combinational so the adder datapath can reuse it.
module fp_rne_round
  import fp_mult_pkg::*;
#(
  parameter int unsigned MAN_W = DEF_MAN_W
) (
  input  logic [MAN_W-1:0] man_i,
  input  logic             guard_i,
  input  logic             sticky_i,
  output logic [MAN_W-1:0] man_c,
  output logic             carry_c
);

  logic inc_c;

  // Round up above half, or exactly at half when the LSB is odd
  always_comb begin
    inc_c            = guard_i & (sticky_i | man_i[0]);
    {carry_c, man_c} = {1'b0, man_i} + (MAN_W + 1)'(inc_c);
  end

endmodule

// File: rtl/fp_mult_norm_round.sv
// Post-multiply normalise / round / pack stage, two pipeline registers.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of fp_mult_norm_round_if (valid/ready in and out)
// Stage 1 normalises the product and resolves specials to a 2-bit code;
// stage 2 rounds to nearest-even, checks range and packs the result.
module fp_mult_norm_round
  import fp_mult_pkg::*;
#(
  parameter int unsigned EXP_W = DEF_EXP_W,
  parameter int unsigned MAN_W = DEF_MAN_W,
  parameter int unsigned BIAS  = (1 << (EXP_W - 1)) - 1
) (
  input  logic               clk,
  input  logic               rst,
  fp_mult_norm_round_if.slave bus
);

  localparam int unsigned E_W    = EXP_W + 2;
  localparam int unsigned PROD_W = 2 * MAN_W + 2;
  localparam int unsigned RES_W  = 1 + EXP_W + MAN_W;
  localparam logic signed [E_W-1:0] E_MAX  = E_W'((1 << EXP_W) - 1);
  localparam logic signed [E_W-1:0] E_ONE  = E_W'(1);
  localparam logic signed [E_W-1:0] E_ZERO = E_W'(0);
  localparam logic [MAN_W-1:0]      QNAN_M = {1'b1, {(MAN_W - 1){1'b0}}};

  logic                    s1_en_c, s2_en_c;
  logic signed [E_W-1:0]   e_base_c, e_rnd_c;
  logic [MAN_W-1:0]        rnd_man_c;
  logic                    rnd_carry_c;

  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_sign_q, s1_sign_d;
  spc_e                    s1_spc_q, s1_spc_d;
  logic signed [E_W-1:0]   s1_e_q, s1_e_d;
  logic [MAN_W-1:0]        s1_man_q, s1_man_d;
  logic                    s1_guard_q, s1_guard_d;
  logic                    s1_sticky_q, s1_sticky_d;

  logic                    out_valid_q, out_valid_d;
  logic [RES_W-1:0]        out_result_q, out_result_d;
  logic                    out_ovf_q, out_ovf_d;
  logic                    out_unf_q, out_unf_d;
  logic                    out_inexact_q, out_inexact_d;

  // Pipeline advance: a stage moves when its successor is empty or draining
  assign s2_en_c      = !out_valid_q || bus.out_ready;
  assign s1_en_c      = !s1_valid_q || s2_en_c;
  assign bus.in_ready = s1_en_c;

  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = out_result_q;
  assign bus.out_ovf     = out_ovf_q;
  assign bus.out_unf     = out_unf_q;
  assign bus.out_inexact = out_inexact_q;

  // Unbiased exponent on a signed range wide enough for both carries
  assign e_base_c = $signed({1'b0, bus.in_exp_sum}) - $signed(E_W'(BIAS));

  // Stage 1: normalise on the product MSB and classify specials
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sign_d   = s1_sign_q;
    s1_spc_d    = s1_spc_q;
    s1_e_d      = s1_e_q;
    s1_man_d    = s1_man_q;
    s1_guard_d  = s1_guard_q;
    s1_sticky_d = s1_sticky_q;
    if (s1_en_c) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_sign_d = bus.in_sign;
        s1_spc_d  = bus.in_nan ? SPC_NAN :
                    bus.in_inf ? SPC_INF :
                    bus.in_zero ? SPC_ZERO : SPC_NONE;
        if (bus.in_prod[PROD_W-1]) begin
          s1_man_d    = bus.in_prod[2*MAN_W -: MAN_W];
          s1_guard_d  = bus.in_prod[MAN_W];
          s1_sticky_d = |bus.in_prod[MAN_W-1:0];
          s1_e_d      = e_base_c + E_ONE;
        end else begin
          s1_man_d    = bus.in_prod[2*MAN_W-1 -: MAN_W];
          s1_guard_d  = bus.in_prod[MAN_W-1];
          s1_sticky_d = |bus.in_prod[MAN_W-2:0];
          s1_e_d      = e_base_c;
        end
      end
    end
  end

  fp_rne_round #(.MAN_W(MAN_W)) u_rnd (
    .man_i    (s1_man_q),
    .guard_i  (s1_guard_q),
    .sticky_i (s1_sticky_q),
    .man_c    (rnd_man_c),
    .carry_c  (rnd_carry_c)
  );

  // Mantissa wrap on carry already yields zero; only the exponent bumps
  assign e_rnd_c = rnd_carry_c ? (s1_e_q + E_ONE) : s1_e_q;

  // Stage 2: range check, special override and packing
  always_comb begin
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_ovf_d     = out_ovf_q;
    out_unf_d     = out_unf_q;
    out_inexact_d = out_inexact_q;
    if (s2_en_c) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_ovf_d     = 1'b0;
        out_unf_d     = 1'b0;
        out_inexact_d = 1'b0;
        case (s1_spc_q)
          SPC_NAN:  out_result_d = {1'b0, {EXP_W{1'b1}}, QNAN_M};
          SPC_INF:  out_result_d = {s1_sign_q, {EXP_W{1'b1}}, MAN_W'(0)};
          SPC_ZERO: out_result_d = {s1_sign_q, EXP_W'(0), MAN_W'(0)};
          default: begin
            if (e_rnd_c >= E_MAX) begin
              out_result_d  = {s1_sign_q, {EXP_W{1'b1}}, MAN_W'(0)};
              out_ovf_d     = 1'b1;
              out_inexact_d = 1'b1;
            end else if (e_rnd_c <= E_ZERO) begin
              out_result_d  = {s1_sign_q, EXP_W'(0), MAN_W'(0)};
              out_unf_d     = 1'b1;
              out_inexact_d = 1'b1;
            end else begin
              out_result_d  = {s1_sign_q, e_rnd_c[EXP_W-1:0], rnd_man_c};
              out_inexact_d = s1_guard_q | s1_sticky_q;
            end
          end
        endcase
      end
    end
  end

  // Pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_spc_q      <= SPC_NONE;
      s1_e_q        <= E_ZERO;
      s1_man_q      <= '0;
      s1_guard_q    <= 1'b0;
      s1_sticky_q   <= 1'b0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_ovf_q     <= 1'b0;
      out_unf_q     <= 1'b0;
      out_inexact_q <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_sign_q     <= s1_sign_d;
      s1_spc_q      <= s1_spc_d;
      s1_e_q        <= s1_e_d;
      s1_man_q      <= s1_man_d;
      s1_guard_q    <= s1_guard_d;
      s1_sticky_q   <= s1_sticky_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_ovf_q     <= out_ovf_d;
      out_unf_q     <= out_unf_d;
      out_inexact_q <= out_inexact_d;
    end
  end

endmodule

// File: tb/tb_fp_mult_norm_round.sv
// Bench for fp_mult_norm_round (half precision): literal corner cases, a
// backpressure burst, random traffic against an arithmetic reference, and a
// mid-stream reset.
module tb_fp_mult_norm_round;
  import fp_mult_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_mult_norm_round_if bus ();

  fp_mult_norm_round dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Each entry: {result[15:0], ovf, unf, inexact}
  logic [18:0] exp_q[$];
  logic        stall_prev = 1'b0;
  logic [18:0] stall_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: real-valued rounding via integer quotient/remainder
  function automatic logic [18:0] model(input int prod, input int es, input bit s,
                                        input bit z, input bit i, input bit n);
    int sh, e, q, r, half;
    bit inx;
    logic [15:0] res;
    if (n) return {16'h7E00, 3'b000};
    if (i) return {s, 15'h7C00, 3'b000};
    if (z) return {s, 15'h0000, 3'b000};
    sh   = (prod >= (1 << 21)) ? 11 : 10;
    e    = es - 15 + (sh - 10);
    q    = prod >> sh;
    r    = prod - (q << sh);
    half = 1 << (sh - 1);
    inx  = (r != 0);
    if (r > half || (r == half && (q % 2) == 1)) q = q + 1;
    if (q == 2048) begin
      q = 1024;
      e = e + 1;
    end
    if (e >= 31) return {s, 15'h7C00, 3'b101};
    if (e <= 0)  return {s, 15'h0000, 3'b011};
    res = {s, e[4:0], q[9:0]};
    return {res, 2'b00, inx};
  endfunction

  // Compare process: scoreboard on every accepted beat and every output beat
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_hold", 32'({bus.out_result, bus.out_ovf, bus.out_unf, bus.out_inexact}),
            32'(stall_val));
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(int'(bus.in_prod), int'(bus.in_exp_sum), bus.in_sign,
                              bus.in_zero, bus.in_inf, bus.in_nan));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%h required=none", bus.out_result);
        end else begin
          chk("stream", 32'({bus.out_result, bus.out_ovf, bus.out_unf, bus.out_inexact}),
              32'(exp_q.pop_front()));
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      stall_val  = {bus.out_result, bus.out_ovf, bus.out_unf, bus.out_inexact};
    end
  end

  // Present one beat and hold it until accepted (bounded)
  task automatic drive(input int prod, input int es, input bit s,
                       input bit z, input bit i, input bit n);
    bit ok = 1'b0;
    bus.in_prod    = 22'(prod);
    bus.in_exp_sum = 6'(es);
    bus.in_sign    = s;
    bus.in_zero    = z;
    bus.in_inf     = i;
    bus.in_nan     = n;
    bus.in_valid   = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=not_accepted required=accepted");
    end
  endtask

  // Single beat with a hand-computed expected result and latency
  task automatic directed(input string name, input int prod, input int es, input bit s,
                          input bit z, input bit i, input bit n,
                          input logic [15:0] res, input logic [2:0] flags);
    int lat = 0;
    bit got = 1'b0;
    bus.out_ready = 1'b1;
    drive(prod, es, s, z, i, n);
    bus.in_valid = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) got = 1'b1;
    end
    chk({name, "_lat"}, 32'(lat), 32'd2);
    chk({name, "_res"}, 32'(bus.out_result), 32'(res));
    chk({name, "_flags"}, 32'({bus.out_ovf, bus.out_unf, bus.out_inexact}), 32'(flags));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_prod    = '0;
    bus.in_exp_sum = '0;
    bus.in_sign    = 1'b0;
    bus.in_zero    = 1'b0;
    bus.in_inf     = 1'b0;
    bus.in_nan     = 1'b0;
    bus.out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_result", 32'(bus.out_result), 32'd0);
    chk("rst_flags", 32'({bus.out_ovf, bus.out_unf, bus.out_inexact}), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // flags order: {ovf, unf, inexact}
    directed("one_x_one",   'h100000, 30, 0, 0, 0, 0, 16'h3C00, 3'b000);
    directed("c15_x_c15",   'h240000, 30, 0, 0, 0, 0, 16'h4080, 3'b000);
    directed("tie_even",    'h100200, 30, 0, 0, 0, 0, 16'h3C00, 3'b001);
    directed("tie_odd",     'h100600, 30, 0, 0, 0, 0, 16'h3C02, 3'b001);
    directed("man_carry",   'h1FFE00, 30, 0, 0, 0, 0, 16'h4000, 3'b001);
    directed("ovf",         'h100000, 60, 0, 0, 0, 0, 16'h7C00, 3'b101);
    directed("unf",         'h100000, 10, 1, 0, 0, 0, 16'h8000, 3'b011);
    directed("nan_inf",     'h100000, 30, 1, 0, 1, 1, 16'h7E00, 3'b000);
    directed("inf_neg",     'h100000, 30, 1, 0, 1, 0, 16'hFC00, 3'b000);
    directed("zero",        'h100000, 30, 0, 1, 0, 0, 16'h0000, 3'b000);
    directed("max_finite",  'h100000, 45, 0, 0, 0, 0, 16'h7800, 3'b000);
    directed("ovf_edge",    'h100000, 46, 0, 0, 0, 0, 16'h7C00, 3'b101);
    directed("min_normal",  'h100000, 16, 0, 0, 0, 0, 16'h0400, 3'b000);
    directed("unf_edge",    'h100000, 15, 0, 0, 0, 0, 16'h0000, 3'b011);

    // Backpressure burst: consumer stalls while four beats are offered
    bus.out_ready = 1'b0;
    fork
      begin
        drive('h100000, 30, 0, 0, 0, 0);
        drive('h240000, 30, 0, 0, 0, 0);
        @(negedge clk);
        chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        drive('h100600, 30, 1, 0, 0, 0);
        drive('h1FFE00, 31, 0, 0, 0, 0);
        bus.in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    chk("bp_drain", 32'(exp_q.size()), 32'd0);

    // Random traffic with random consumer stalls
    for (int c = 0; c < 500; c++) begin
      bus.in_valid   = ($urandom % 4) != 0;
      bus.in_prod    = 22'($urandom_range(32'h3FFFFF, 32'h100000));
      bus.in_exp_sum = 6'($urandom_range(63, 0));
      bus.in_sign    = 1'($urandom % 2);
      bus.in_nan     = ($urandom % 16) == 0;
      bus.in_inf     = ($urandom % 12) == 0;
      bus.in_zero    = ($urandom % 12) == 0;
      bus.out_ready  = ($urandom % 4) != 0;
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.in_nan    = 1'b0;
    bus.in_inf    = 1'b0;
    bus.in_zero   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rand_drain", 32'(exp_q.size()), 32'd0);

    // Reset with beats in flight discards them
    bus.out_ready = 1'b0;
    drive('h240000, 30, 0, 0, 0, 0);
    drive('h100200, 30, 0, 0, 0, 0);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    directed("post_rst", 'h100000, 30, 0, 0, 0, 0, 16'h3C00, 3'b000);
    repeat (3) @(posedge clk);
    #1;
    chk("final_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
